// File: rtl/cr_kme_param_fifo_pkg.sv
// Shared types and helpers for the parametrised KME stall FIFO.
package cr_kme_param_fifo_pkg;

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic hwm_update;
   } fifo_flags_t;

endpackage

// File: rtl/cr_kme_param_fifo_regfile.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset on contents.
module cr_kme_param_fifo_regfile #(
   parameter int unsigned DATA_SIZE  = 83,
   parameter int unsigned FIFO_DEPTH = 25,
   parameter int unsigned PTR_W      = 5
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [PTR_W-1:0]     waddr,
   input  logic [DATA_SIZE-1:0] wdata,
   input  logic [PTR_W-1:0]     raddr,
   output logic [DATA_SIZE-1:0] rdata
);

   logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_SIZE-1:0] mem_d [FIFO_DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/cr_kme_param_fifo.sv
// First-word-fall-through FIFO with early stall, flush, slot counts and flag pulses.
// Optional high-water mark enabled by defining CR_KME_PARAM_FIFO_HWM_EN.
module cr_kme_param_fifo
   import cr_kme_param_fifo_pkg::*;
#(
   parameter int unsigned DATA_SIZE   = 83,
   parameter int unsigned FIFO_DEPTH  = 25,
   parameter int unsigned STALL_AT    = 0,
   parameter bit          PROG_STALL  = 1'b0,
   parameter bit          OVERRIDE_EN = 1'b0,
   localparam int unsigned CNT_W      = cnt_width(FIFO_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_SIZE-1:0] fifo_in,
   input  logic                 fifo_in_valid,
   output logic                 fifo_in_stall,
   input  logic                 fifo_in_stall_override,
   input  logic [CNT_W-1:0]     stall_at,
   input  logic                 clear,
   output logic [DATA_SIZE-1:0] fifo_out,
   output logic                 fifo_out_valid,
   input  logic                 fifo_out_ack,
   output logic [CNT_W-1:0]     used_slots,
   output logic [CNT_W-1:0]     free_slots,
   output logic                 fifo_overflow,
   output logic                 fifo_underflow,
   output logic [CNT_W-1:0]     fifo_hwm
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] used_q, used_d;
   logic             ovf_q, udf_q;
   logic [CNT_W-1:0] hwm_cur;
   fifo_flags_t      flags_d;
   logic             full, empty, wen, ren;
   logic [31:0]      thr;
   logic             stall_raw;

   // Pointers wrap at FIFO_DEPTH-1, so the depth need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      full     = (used_q == CNT_W'(FIFO_DEPTH));
      empty    = (used_q == '0);
      ren      = ~empty & fifo_out_ack;
      wen      = fifo_in_valid & (~full | ren);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      used_d   = used_q;
      flags_d  = '0;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         used_d   = '0;
      end else begin
         if (wen) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (ren) rd_ptr_d = ptr_inc(rd_ptr_q);
         used_d             = used_q + CNT_W'(wen) - CNT_W'(ren);
         flags_d.overflow   = fifo_in_valid & full & ~ren;
         flags_d.underflow  = fifo_out_ack & empty;
         flags_d.hwm_update = (used_q > hwm_cur);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         used_q   <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         used_q   <= used_d;
         ovf_q    <= flags_d.overflow;
         udf_q    <= flags_d.underflow;
      end
   end

`ifdef CR_KME_PARAM_FIFO_HWM_EN
   logic [CNT_W-1:0] hwm_q, hwm_d;

   // Tracks registered occupancy, so the mark trails used_slots by one edge.
   always_comb begin
      hwm_d = hwm_q;
      if (clear) begin
         hwm_d = '0;
      end else if (flags_d.hwm_update) begin
         hwm_d = used_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hwm_q <= '0;
      end else begin
         hwm_q <= hwm_d;
      end
   end

   assign hwm_cur  = hwm_q;
   assign fifo_hwm = hwm_q;
`else
   logic unused_hwm_update;
   assign unused_hwm_update = flags_d.hwm_update;
   assign hwm_cur  = '0;
   assign fifo_hwm = '0;
`endif

   cr_kme_param_fifo_regfile #(
      .DATA_SIZE  (DATA_SIZE),
      .FIFO_DEPTH (FIFO_DEPTH),
      .PTR_W      (PTR_W)
   ) u_regfile (
      .clk   (clk),
      .we    (wen & ~clear),
      .waddr (wr_ptr_q),
      .wdata (fifo_in),
      .raddr (rd_ptr_q),
      .rdata (fifo_out)
   );

   // A threshold at or above the depth keeps the stall permanently asserted.
   always_comb begin
      thr       = PROG_STALL ? 32'(stall_at) : 32'(STALL_AT);
      stall_raw = (32'(free_slots) <= thr);
   end

   assign fifo_in_stall  = stall_raw & ~(OVERRIDE_EN & fifo_in_stall_override);
   assign fifo_out_valid = ~empty;
   assign used_slots     = used_q;
   assign free_slots     = CNT_W'(FIFO_DEPTH) - used_q;
   assign fifo_overflow  = ovf_q;
   assign fifo_underflow = udf_q;

endmodule

// File: doc/cr_kme_param_fifo.md
Name: cr_kme_param_fifo

Overview:
Parametrised successor of the KME stall-signalling FIFO.
- Buffers DATA_SIZE-bit words in a first-word-fall-through queue with a valid/ack output handshake.
- Raises an early stall towards the producer; the stall threshold is either compile-time or programmable at run time.
- Adds synchronous flush, exported slot counts, ack-on-empty underflow detection and an optional high-water mark.
- Sits between KME pipeline stages wherever the producer needs early backpressure.

Parameters:
DATA_SIZE, 83, word width in bits.
FIFO_DEPTH, 25, number of entries; need not be a power of two; must be ≥ 2.
STALL_AT, 0, fixed stall threshold in free slots; used when PROG_STALL=0.
PROG_STALL, 0, 1 = threshold taken from the stall_at port instead of STALL_AT.
OVERRIDE_EN, 0, 1 = fifo_in_stall_override is honoured; 0 = override port ignored.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  reset; synchronous, active-low.
fifo_in  in  DATA_SIZE  write data.
fifo_in_valid  in  1  write enable.
fifo_in_stall  out  1  producer backpressure.
fifo_in_stall_override  in  1  forces fifo_in_stall low (OVERRIDE_EN=1 only).
stall_at  in  CNT_W  run-time stall threshold (PROG_STALL=1 only).
clear  in  1  synchronous flush.
fifo_out  out  DATA_SIZE  head-of-queue data.
fifo_out_valid  out  1  queue non-empty.
fifo_out_ack  in  1  consumer pop.
used_slots  out  CNT_W  occupied entries.
free_slots  out  CNT_W  FIFO_DEPTH - used_slots.
fifo_overflow  out  1  one-cycle pulse on a dropped write.
fifo_underflow  out  1  one-cycle pulse on ack while empty.
fifo_hwm  out  CNT_W  high-water mark (see Optional Feature).
CNT_W = $clog2(FIFO_DEPTH+1).

Behaviour:
- Reset (rst_n=0 at a clk edge): pointers, count, fifo_overflow, fifo_underflow and fifo_hwm all 0.
  - fifo_out_valid=0, used_slots=0, free_slots=FIFO_DEPTH.
  - fifo_out is don't-care but driven, with no X propagation requirement on valid.
  - Reset asserted mid-operation discards all contents on that edge.
- Write: wen = fifo_in_valid & (!full | ren). Data written at wr_ptr. wr_ptr wraps FIFO_DEPTH-1 → 0.
- Read: ren = fifo_out_valid & fifo_out_ack. rd_ptr advances and wraps the same way.
- Latency: a word written at edge N is presented on fifo_out with fifo_out_valid=1 after edge N; first-word fall-through, no extra register stage.
- Count update: used += wen - ren. Simultaneous read and write leaves the count unchanged and is legal when full (the write is accepted).
- Overflow: fifo_in_valid=1, full and no ren → write dropped, contents unchanged, fifo_overflow=1 for the next cycle.
- Underflow: fifo_out_ack=1 while empty → nothing popped, fifo_underflow=1 for the next cycle.
- Stall:
  - thr = PROG_STALL ? stall_at : STALL_AT.
  - fifo_in_stall = (free_slots <= thr) computed combinationally from registered free_slots, then forced to 0 when OVERRIDE_EN & fifo_in_stall_override.
  - thr ≥ FIFO_DEPTH means permanently stalled.
  - Stall is advisory: writes while stalled are accepted if not full.
- Clear:
  - Has priority over wen and ren in the same cycle. Pointers and count go to 0.
  - No overflow or underflow pulse is generated in a clear cycle.
- Flag pulses are registered, single-cycle, and not sticky.

Optional Feature:
CR_KME_PARAM_FIFO_HWM_EN.
- Defined:
  - fifo_hwm registers the maximum used_slots value seen since reset or clear.
  - Updated on the edge after used_slots rises; saturates at FIFO_DEPTH.
  - Cleared to 0 by rst_n or clear.
- Undefined: fifo_hwm tied to 0, no register inferred.

Decomposition:
- Package cr_kme_param_fifo_pkg: CNT_W computation function and a flag-struct typedef holding overflow, underflow and hwm_update.
- One sub-module, cr_kme_param_fifo_regfile: a FIFO_DEPTH x DATA_SIZE storage array with a synchronous write port and an asynchronous read port.
- Pointer, count, stall and flag logic stays in the top module.

Test Plan (DATA_SIZE=83, FIFO_DEPTH=25, STALL_AT=3, macro defined unless noted):
1. Reset, then write 22 words (0..21) with no ack → fifo_in_stall=1 exactly after word 22 (free_slots=3), fifo_out=0, valid=1, used_slots=22, fifo_hwm=22.
2. Fill to 25, hold fifo_in_valid one more cycle with ack=0 → fifo_overflow pulses once, used_slots stays 25. Repeat with ack=1 → no overflow, count stays 25, order preserved.
3. Non-power-of-2 wrap: stream 100 words with ack every cycle → output sequence equals input, no flags, used_slots ≤ 1.
4. Empty FIFO, fifo_out_ack=1 for 2 cycles → fifo_underflow high for 2 cycles, used_slots=0. Same with clear=1 → no pulse.
5. PROG_STALL=1, stall_at=10, 15 entries (free=10) → stall=1. stall_at=9 → stall=0 on the same cycle. OVERRIDE_EN=1 with override=1 → stall=0.
6. 12 entries, then clear together with a write and an ack → used_slots=0, valid=0, fifo_hwm=0. rst_n=0 mid-stream → all outputs at reset values on the next edge. Macro undefined → fifo_hwm=0 throughout.
